// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO and its read-side stream adapter:
// default word width and skid-buffer occupancy encodings.
package fifo_pkg;

    localparam int unsigned FIFO_DW = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    function automatic logic [2:0] occ_level(input occ_t o);
        return {1'b0, o};
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; head is always entry 0, entry 1 is the tail
// when two words are held. Push into a full buffer without a pop must not occur.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output occ_t          occ
);

    occ_t          occ_nxt;
    logic [DW-1:0] ent0, ent1, ent0_nxt, ent1_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= OCC_EMPTY;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            occ  <= occ_nxt;
            ent0 <= ent0_nxt;
            ent1 <= ent1_nxt;
        end
    end

    always_comb begin
        occ_nxt  = occ;
        ent0_nxt = ent0;
        ent1_nxt = ent1;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    ent0_nxt = push_data;
                    occ_nxt  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push, pop})
                    2'b11: ent0_nxt = push_data;
                    2'b10: begin
                        ent1_nxt = push_data;
                        occ_nxt  = OCC_TWO;
                    end
                    2'b01: occ_nxt = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                // Pop shifts the tail to the head; a concurrent push refills the tail.
                if (pop) begin
                    ent0_nxt = ent1;
                    if (push) ent1_nxt = push_data;
                    else      occ_nxt  = OCC_ONE;
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
    end

    assign head = ent0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port (data one cycle after rd_en) into a valid/ready stream.
// Define FIFO_RD_STREAM_CNT_EN to add the xfer_count accepted-word counter.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DW = FIFO_DW
`ifdef FIFO_RD_STREAM_CNT_EN
   ,parameter int unsigned CW = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd_en,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
   ,output logic [CW-1:0] xfer_count
`endif
);

    occ_t       occ;
    logic       pend;
    logic       pop;
    logic [2:0] level;

    assign m_valid = (occ != OCC_EMPTY);
    assign pop     = m_valid & m_ready;

    // Entries held after this edge, counting the word already in flight.
    assign level      = occ_level(occ) + {2'b00, pend} - {2'b00, pop};
    assign fifo_rd_en = !rst && !fifo_empty && (level < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) pend <= 1'b0;
        else     pend <= fifo_rd_en;
    end

    fifo_skid_buf #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pend),
        .push_data (fifo_data),
        .pop       (pop),
        .head      (m_data),
        .occ       (occ)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)      xfer_count <= '0;
        else if (pop) xfer_count <= xfer_count + CW'(1);
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomised checks of fifo_rd_stream against a behavioural FIFO
// model and an output scoreboard.
module tb_fifo_rd_stream;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] xfer_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] in_q[$];
    logic [7:0] fq[$];
    logic [7:0] out_q[$];
    int rd_pulses = 0;
    int pops      = 0;
    int occ_viol  = 0;
    int cap_drop  = 0;
    int model_err = 0;

    fifo_rd_stream #(
        .DW (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
       ,.xfer_count (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model (registered read data) plus output monitor.
    always @(posedge clk) begin
        while (in_q.size() > 0) fq.push_back(in_q.pop_front());
        if (fifo_rd_en) begin
            rd_pulses++;
            if (fq.size() == 0) model_err++;
            else                fifo_data <= fq.pop_front();
        end
        if (!rst && m_valid && m_ready) begin
            out_q.push_back(m_data);
            pops++;
        end
        if (2'(dut.u_skid.occ) > 2'd2) occ_viol++;
        if (!rst && dut.pend && dut.u_skid.occ == OCC_TWO && !(m_valid && m_ready)) cap_drop++;
        fifo_empty <= (fq.size() == 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_outs(input int n, input string name);
        int cyc = 0;
        while (out_q.size() < n && cyc < 200) begin
            tick();
            cyc++;
        end
        total++;
        if (out_q.size() < n) begin
            bad++;
            $display("FAIL %s timeout: got %0d words, need %0d", name, out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_ready = 1'b0;
        in_q.push_back(8'h3C);
        repeat (3) tick();
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        total++; if (m_data !== 8'h00)    begin bad++; $display("FAIL reset_m_data got %h want 00", m_data); end
        rst = 1'b0;
        #1;
        total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL reset_release_rd_en got %b want 1", fifo_rd_en); end
        m_ready = 1'b1;
        wait_outs(1, "reset_drain");
        total++; if (out_q.size() < 1 || out_q[0] !== 8'h3C) begin bad++; $display("FAIL reset_drain_word got %h want 3c", out_q.size() > 0 ? out_q[0] : 8'hxx); end
        repeat (2) tick();
    endtask

    task automatic test_latency();
        m_ready = 1'b1;
        in_q.push_back(8'hA5);
        tick();
        total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL latency_rd_en_N got %b want 1", fifo_rd_en); end
        total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL latency_valid_N got %b want 0", m_valid); end
        tick();
        total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL latency_valid_N1 got %b want 0", m_valid); end
        tick();
        total++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin bad++; $display("FAIL latency_N2 got v=%b d=%h want v=1 d=a5", m_valid, m_data); end
        tick();
        total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL latency_valid_N3 got %b want 0", m_valid); end
        repeat (2) tick();
    endtask

    task automatic test_streaming();
        int cyc = 0;
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) in_q.push_back(8'(i));
        while (!m_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        for (int i = 1; i <= 16; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
                bad++;
                $display("FAIL stream_word%0d got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, 8'(i));
            end
            tick();
        end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got %b want 0", m_valid); end
`ifdef FIFO_RD_STREAM_CNT_EN
        total++; if (xfer_count !== 16'(pops)) begin bad++; $display("FAIL stream_xfer_count got %0d want %0d", xfer_count, pops); end
`endif
        repeat (2) tick();
    endtask

    task automatic test_backpressure();
        int r0;
        int ob;
        m_ready = 1'b0;
        r0 = rd_pulses;
        ob = out_q.size();
        for (int i = 0; i < 5; i++) in_q.push_back(8'h51 + 8'(i));
        repeat (8) tick();
        total++; if (rd_pulses - r0 != 2) begin bad++; $display("FAIL bp_rd_pulses got %0d want 2", rd_pulses - r0); end
        total++; if (m_valid !== 1'b1 || m_data !== 8'h51) begin bad++; $display("FAIL bp_hold got v=%b d=%h want v=1 d=51", m_valid, m_data); end
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en got %b want 0", fifo_rd_en); end
        m_ready = 1'b1;
        wait_outs(ob + 5, "bp_drain");
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_q.size() <= ob + i || out_q[ob + i] !== 8'h51 + 8'(i)) begin
                bad++;
                $display("FAIL bp_word%0d got %h want %h", i, out_q.size() > ob + i ? out_q[ob + i] : 8'hxx, 8'h51 + 8'(i));
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] w;
        int ob;
        ob = out_q.size();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                w = 8'($urandom_range(0, 255));
                in_q.push_back(w);
                exp_q.push_back(w);
            end
            m_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        m_ready = 1'b1;
        wait_outs(ob + exp_q.size(), "rand_drain");
        repeat (4) tick();
        total++; if (out_q.size() != ob + exp_q.size()) begin bad++; $display("FAIL rand_count got %0d want %0d", out_q.size() - ob, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (out_q.size() > ob + i) begin
                total++;
                if (out_q[ob + i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand_word%0d got %h want %h", i, out_q[ob + i], exp_q[i]);
                end
            end
        end
        total++; if (occ_viol != 0)  begin bad++; $display("FAIL rand_occ_bound got %0d violations want 0", occ_viol); end
        total++; if (cap_drop != 0)  begin bad++; $display("FAIL rand_capture_drop got %0d want 0", cap_drop); end
        total++; if (model_err != 0) begin bad++; $display("FAIL rand_read_empty got %0d want 0", model_err); end
    endtask

    task automatic test_mid_reset();
        int ob;
        m_ready = 1'b0;
        ob = out_q.size();
        for (int i = 0; i < 4; i++) in_q.push_back(8'h71 + 8'(i));
        repeat (3) tick();
        total++; if (dut.pend !== 1'b1 || dut.u_skid.occ !== OCC_ONE) begin bad++; $display("FAIL midrst_setup got pend=%b occ=%0d want pend=1 occ=1", dut.pend, dut.u_skid.occ); end
        rst = 1'b1;
        #1;
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL midrst_rd_en got %b want 0", fifo_rd_en); end
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b want 0", m_valid); end
        total++; if (dut.u_skid.occ !== OCC_EMPTY || dut.pend !== 1'b0) begin bad++; $display("FAIL midrst_state got occ=%0d pend=%b want occ=0 pend=0", dut.u_skid.occ, dut.pend); end
`ifdef FIFO_RD_STREAM_CNT_EN
        total++; if (xfer_count !== 16'd0) begin bad++; $display("FAIL midrst_xfer_count got %0d want 0", xfer_count); end
`else
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL midrst_m_data got %h want 00", m_data); end
`endif
        rst = 1'b0;
        m_ready = 1'b1;
        wait_outs(ob + 2, "midrst_drain");
        repeat (3) tick();
        total++; if (out_q.size() != ob + 2) begin bad++; $display("FAIL midrst_count got %0d want 2", out_q.size() - ob); end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (out_q.size() <= ob + i || out_q[ob + i] !== 8'h73 + 8'(i)) begin
                bad++;
                $display("FAIL midrst_word%0d got %h want %h", i, out_q.size() > ob + i ? out_q[ob + i] : 8'hxx, 8'h73 + 8'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
